tx_8b10b_sched: RTL and testbench
=================================

Name: tx_8b10b_sched

Overview:
- Transmit-side scheduler for the 8b/10b encoder pipeline. It sits ahead of the 5b/6b and 3b/4b encode stages and decides what symbol is encoded each cycle.
- After enable, it runs a comma alignment burst. It then accepts user bytes through a valid/ready handshake, fills gaps with idle characters and inserts periodic commas.
- It also screens illegal control characters and tracks running disparity from encoder feedback.

Parameters:
- ALIGN_CNT, 16: number of K28.5 commas sent in ALIGN (legal range 1..255).
- SYNC_PERIOD, 256: RUN symbols between forced commas, counting the comma itself (legal range 2..65535).
- IDLE_CHAR, 8'h1C: idle fill byte, always sent with K=1 (K28.0).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- tx_en, input, 1: link enable, level sensitive.
- s_valid, input, 1: upstream byte valid.
- s_data, input, 8: upstream byte (HGF_EDCBA).
- s_k, input, 1: upstream byte is a control character.
- s_ready, output, 1: scheduler accepts s_data this cycle.
- enc_valid, output, 1: registered; the enc_* fields are a live symbol.
- enc_data, output, 8: registered byte to the encoder; low 5 bits feed the 5b/6b stage.
- enc_K, output, 1: registered control flag to the encoder.
- enc_flip, input, 1: encoder reports that the symbol it just produced flipped running disparity.
- rd_cur, output, 1: registered running disparity (0 = RD-, 1 = RD+).
- link_up, output, 1: registered; high while in RUN.
- err_k, output, 1: registered one-cycle pulse when an illegal control character was accepted.

Behaviour:
- Reset values: enc_valid=0, enc_data=8'h00, enc_K=0, rd_cur=0, link_up=0, err_k=0, state=OFF, counters=0.
- States: OFF, ALIGN, RUN. State is encoded in registers. s_ready is combinational from state and counters only and never depends on s_valid.
- OFF:
  - enc_valid=0, enc_data=0, enc_K=0, s_ready=0.
  - tx_en=1 moves to ALIGN on the next edge and clears the align counter.
- ALIGN:
  - Each cycle registers enc_data=8'hBC, enc_K=1, enc_valid=1. s_ready=0.
  - After exactly ALIGN_CNT symbols, moves to RUN. link_up rises on the same edge as the first RUN symbol.
- RUN, with priority in this order:
  1. Sync due (sync counter == SYNC_PERIOD-1): emit 8'hBC/K=1. s_ready=0. Sync counter wraps to 0.
  2. s_valid=1 (s_ready=1): transfer occurs; emit s_data/s_k.
  3. Otherwise: emit IDLE_CHAR/K=1.
- In RUN, the sync counter increments on every symbol. enc_valid=1 every RUN cycle.
- Latency: an accepted byte appears on enc_data on the clock edge that accepts it, so it is visible one cycle after the handshake cycle.
- Legal K set: 1C, 3C, 5C, 7C, 9C, BC, DC, FC, F7, FB, FD, FE. If s_k=1 and s_data is outside this set:
  - the byte is still consumed (s_ready honoured);
  - IDLE_CHAR/K=1 is emitted instead;
  - err_k pulses on that edge.
  - Back-to-back illegal bytes give consecutive err_k pulses.
- s_k=0: any byte is legal.
- Disparity: rd_cur toggles on each edge where enc_flip=1, in any state. Disparity is not otherwise recomputed here.
- tx_en falls in ALIGN or RUN:
  - next edge enters OFF; enc_valid=0; s_ready=0 from that cycle; link_up=0.
  - Align and sync counters clear. rd_cur holds.
  - A byte presented in the same cycle tx_en falls is still accepted if s_ready=1 in that cycle, and it is emitted on that edge.
- tx_en re-asserted: always restarts ALIGN from count 0.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronously). No partial symbol is emitted.

Optional Feature:
- Macro SYNC_INSERT_EN.
- Defined: periodic comma insertion as described above.
- Undefined: the sync counter and rule 1 are removed. In RUN, s_ready=1 every cycle and only data or idle are emitted. All other behaviour is identical.

Test Plan:
- Reset, then tx_en=1, ALIGN_CNT=4 → exactly 4 cycles of enc_data=BC/K=1, s_ready=0, link_up=0; link_up=1 with the first RUN symbol.
- In RUN with s_valid low → enc_data=1C, K=1 each cycle. Then push 8'h4A/s_k=0 → next cycle enc_data=4A, K=0, one transfer only.
- SYNC_INSERT_EN, SYNC_PERIOD=8, s_valid held high with incrementing data 00..0F → every 8th RUN symbol is BC/K=1 with s_ready=0, and no byte is lost or duplicated.
- s_k=1, s_data=8'h3D → byte consumed, enc_data=1C/K=1, err_k=1 for one cycle. s_k=1, s_data=8'hFB → passed through, err_k=0.
- enc_flip pulsed 3 times from reset → rd_cur sequence 1,0,1. Reset asserted mid-RUN → rd_cur=0 and enc_valid=0 immediately.
- tx_en dropped mid-RUN, then raised after 5 cycles → enc_valid low for those cycles, then a full ALIGN burst of ALIGN_CNT commas before data resumes.

Source files
------------

// File: rtl/tx_8b10b_sched.sv
// -----------------------------------------------------------------------------
// tx_8b10b_sched
//
// Transmit-side symbol scheduler ahead of the 5b/6b + 3b/4b encode stages.
// After tx_en rises it sends a burst of ALIGN_CNT K28.5 commas. It then
// enters RUN, where it accepts user bytes over a valid/ready handshake, fills
// gaps with IDLE_CHAR (always K=1), and screens illegal control characters.
// Running disparity is tracked from encoder feedback.
//
// Optional feature macro: SYNC_INSERT_EN
//   defined   : a K28.5 comma is forced every SYNC_PERIOD RUN symbols
//               (the comma itself counts as one of them).
//   undefined : no sync counter; s_ready is high on every RUN cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   tx_en             link enable (level)
//   s_valid/s_data/s_k  upstream byte (HGF_EDCBA) and its control flag
//   s_ready           byte accepted this cycle (from state/counters only)
//   enc_valid/enc_data/enc_K  registered symbol to the encoder
//   enc_flip          encoder flipped running disparity on its last symbol
//   rd_cur            registered running disparity (0 = RD-, 1 = RD+)
//   link_up           registered, high while RUN symbols are being sent
//   err_k             registered pulse: an illegal control byte was consumed
//
// A byte accepted in the cycle tx_en falls is still emitted on that edge;
// otherwise that edge emits nothing (enc_valid=0).
// -----------------------------------------------------------------------------
module tx_8b10b_sched #(
   parameter int          ALIGN_CNT   = 16,
   parameter int          SYNC_PERIOD = 256,
   parameter logic [7:0]  IDLE_CHAR   = 8'h1C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_k,
   output logic       s_ready,
   output logic       enc_valid,
   output logic [7:0] enc_data,
   output logic       enc_K,
   input  logic       enc_flip,
   output logic       rd_cur,
   output logic       link_up,
   output logic       err_k
);

   localparam logic [7:0] K28_5      = 8'hBC;
   localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CNT - 1);

   // Parameter range guard, evaluated at elaboration only.
   if (ALIGN_CNT < 1 || ALIGN_CNT > 255 || SYNC_PERIOD < 2 || SYNC_PERIOD > 65535) begin : g_param_chk
      $error("tx_8b10b_sched: ALIGN_CNT or SYNC_PERIOD out of range");
   end

   typedef enum logic [1:0] {ST_OFF, ST_ALIGN, ST_RUN} state_t;

   state_t     state_q, state_d;
   logic [7:0] align_cnt_q, align_cnt_d;
   logic       enc_valid_q, enc_valid_d;
   logic [7:0] enc_data_q, enc_data_d;
   logic       enc_k_q, enc_k_d;
   logic       rd_cur_q, rd_cur_d;
   logic       link_up_q, link_up_d;
   logic       err_k_q, err_k_d;
   logic       sync_due;
   logic       take;
   logic       k_bad;

`ifdef SYNC_INSERT_EN
   localparam logic [15:0] SYNC_LAST = 16'(SYNC_PERIOD - 1);
   logic [15:0] sync_cnt_q, sync_cnt_d;
   assign sync_due = (state_q == ST_RUN) && (sync_cnt_q == SYNC_LAST);
`else
   assign sync_due = 1'b0;
`endif

   function automatic logic is_legal_k(input logic [7:0] b);
      case (b)
         8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
         8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: is_legal_k = 1'b1;
         default:                                  is_legal_k = 1'b0;
      endcase
   endfunction

   // Ready deliberately ignores s_valid and tx_en so upstream never sees a
   // combinational loop through the handshake.
   assign s_ready = (state_q == ST_RUN) && !sync_due;
   assign take    = s_ready && s_valid;
   assign k_bad   = s_k && !is_legal_k(s_data);

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational blocks below use blocking (=).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_OFF;
         align_cnt_q <= '0;
`ifdef SYNC_INSERT_EN
         sync_cnt_q  <= '0;
`endif
         enc_valid_q <= 1'b0;
         enc_data_q  <= '0;
         enc_k_q     <= 1'b0;
         rd_cur_q    <= 1'b0;
         link_up_q   <= 1'b0;
         err_k_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         align_cnt_q <= align_cnt_d;
`ifdef SYNC_INSERT_EN
         sync_cnt_q  <= sync_cnt_d;
`endif
         enc_valid_q <= enc_valid_d;
         enc_data_q  <= enc_data_d;
         enc_k_q     <= enc_k_d;
         rd_cur_q    <= rd_cur_d;
         link_up_q   <= link_up_d;
         err_k_q     <= err_k_d;
      end
   end

   // Next-state and counters
   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d     = state_q;
      align_cnt_d = align_cnt_q;
`ifdef SYNC_INSERT_EN
      sync_cnt_d  = sync_cnt_q;
`endif
      case (state_q)
         ST_OFF: begin
            align_cnt_d = '0;
`ifdef SYNC_INSERT_EN
            sync_cnt_d  = '0;
`endif
            if (tx_en) state_d = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (!tx_en) begin
               state_d     = ST_OFF;
               align_cnt_d = '0;
            end else if (align_cnt_q == ALIGN_LAST) begin
               state_d     = ST_RUN;
               align_cnt_d = '0;
            end else begin
               align_cnt_d = align_cnt_q + 8'd1;
            end
         end
         ST_RUN: begin
            if (!tx_en) begin
               state_d = ST_OFF;
`ifdef SYNC_INSERT_EN
               sync_cnt_d = '0;
            end else begin
               sync_cnt_d = sync_due ? 16'd0 : sync_cnt_q + 16'd1;
`endif
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Registered outputs
   always_comb begin
      enc_valid_d = 1'b0;
      enc_data_d  = '0;
      enc_k_d     = 1'b0;
      link_up_d   = 1'b0;
      err_k_d     = 1'b0;
      rd_cur_d    = rd_cur_q ^ enc_flip;
      case (state_q)
         ST_ALIGN: begin
            if (tx_en) begin
               enc_valid_d = 1'b1;
               enc_data_d  = K28_5;
               enc_k_d     = 1'b1;
            end
         end
         ST_RUN: begin
            link_up_d = tx_en;
            if (tx_en && sync_due) begin
               enc_valid_d = 1'b1;
               enc_data_d  = K28_5;
               enc_k_d     = 1'b1;
            end else if (take) begin
               // Illegal control bytes are consumed but replaced by idle.
               enc_valid_d = 1'b1;
               enc_data_d  = k_bad ? IDLE_CHAR : s_data;
               enc_k_d     = k_bad ? 1'b1 : s_k;
               err_k_d     = k_bad;
            end else if (tx_en) begin
               enc_valid_d = 1'b1;
               enc_data_d  = IDLE_CHAR;
               enc_k_d     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign enc_valid = enc_valid_q;
   assign enc_data  = enc_data_q;
   assign enc_K     = enc_k_q;
   assign rd_cur    = rd_cur_q;
   assign link_up   = link_up_q;
   assign err_k     = err_k_q;

endmodule

// File: tb/tb_tx_8b10b_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_8b10b_sched
//
// Directed + randomized bench for tx_8b10b_sched (ALIGN_CNT=4, SYNC_PERIOD=8).
// A behavioural model (mode + count-down comma budget + position within the
// sync period) predicts s_ready each cycle and the registered outputs after
// each edge. Works with SYNC_INSERT_EN defined or not.
// -----------------------------------------------------------------------------
module tb_tx_8b10b_sched;

   localparam int         ALIGN_CNT   = 4;
   localparam int         SYNC_PERIOD = 8;
   localparam logic [7:0] IDLE        = 8'h1C;
   localparam logic [7:0] COMMA       = 8'hBC;
`ifdef SYNC_INSERT_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic       clk, rst_n, tx_en, s_valid, s_k, s_ready;
   logic [7:0] s_data, enc_data;
   logic       enc_valid, enc_K, enc_flip, rd_cur, link_up, err_k;

   tx_8b10b_sched #(.ALIGN_CNT(ALIGN_CNT), .SYNC_PERIOD(SYNC_PERIOD), .IDLE_CHAR(IDLE)) dut (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
      .s_valid(s_valid), .s_data(s_data), .s_k(s_k), .s_ready(s_ready),
      .enc_valid(enc_valid), .enc_data(enc_data), .enc_K(enc_K),
      .enc_flip(enc_flip), .rd_cur(rd_cur), .link_up(link_up), .err_k(err_k)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   // ---------------- reference model ----------------
   typedef enum {M_OFF, M_ALIGN, M_RUN} mode_t;
   mode_t      m_mode;
   int         commas_left;   // ALIGN commas still to send
   int         since_comma;   // RUN symbols since the last forced comma
   bit         m_rd;
   bit         e_valid, e_k, e_link, e_err;
   logic [7:0] e_data;
   logic [7:0] out_q [$];     // data bytes (K=0) seen on the encoder side

   function automatic bit is_legal(input logic [7:0] b);
      foreach (legal_k[i]) if (legal_k[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      return (m_mode == M_RUN) && !(SYNC_ON && since_comma == SYNC_PERIOD - 1);
   endfunction

   task automatic model_reset();
      m_mode = M_OFF; commas_left = 0; since_comma = 0; m_rd = 1'b0;
      e_valid = 1'b0; e_data = 8'h00; e_k = 1'b0; e_link = 1'b0; e_err = 1'b0;
   endtask

   task automatic model_step(input bit en, v, input logic [7:0] d, input bit k, flip);
      bit due;
      due = SYNC_ON && (m_mode == M_RUN) && (since_comma == SYNC_PERIOD - 1);
      e_valid = 1'b0; e_data = 8'h00; e_k = 1'b0; e_link = 1'b0; e_err = 1'b0;
      m_rd = m_rd ^ flip;
      case (m_mode)
         M_OFF: if (en) begin m_mode = M_ALIGN; commas_left = ALIGN_CNT; end
         M_ALIGN: begin
            if (!en) m_mode = M_OFF;
            else begin
               e_valid = 1'b1; e_data = COMMA; e_k = 1'b1;
               commas_left--;
               if (commas_left == 0) begin m_mode = M_RUN; since_comma = 0; end
            end
         end
         M_RUN: begin
            e_link = en;
            if (en && due) begin
               e_valid = 1'b1; e_data = COMMA; e_k = 1'b1;
            end else if (!due && v) begin
               e_valid = 1'b1;
               if (k && !is_legal(d)) begin e_data = IDLE; e_k = 1'b1; e_err = 1'b1; end
               else begin e_data = d; e_k = k; end
            end else if (en) begin
               e_valid = 1'b1; e_data = IDLE; e_k = 1'b1;
            end
            if (!en) m_mode = M_OFF;
            else since_comma = (since_comma + 1) % SYNC_PERIOD;
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, ".enc_valid"}, 8'(enc_valid), 8'(e_valid));
      check({pfx, ".enc_data"},  enc_data,       e_data);
      check({pfx, ".enc_K"},     8'(enc_K),     8'(e_k));
      check({pfx, ".link_up"},   8'(link_up),   8'(e_link));
      check({pfx, ".err_k"},     8'(err_k),     8'(e_err));
      check({pfx, ".rd_cur"},    8'(rd_cur),    8'(m_rd));
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic cycle(input bit en, v, input logic [7:0] d, input bit k, flip);
      tx_en = en; s_valid = v; s_data = d; s_k = k; enc_flip = flip;
      #1;
      check("s_ready", 8'(s_ready), 8'(m_ready()));
      model_step(en, v, d, k, flip);
      @(posedge clk); #1;
      check_outputs("cyc");
      if (enc_valid && !enc_K) out_q.push_back(enc_data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] nxt;
      int         guard;
      bit         rk;
      logic [7:0] rd8;

      tx_en = 0; s_valid = 0; s_data = 0; s_k = 0; enc_flip = 0;
      rst_n = 0;
      model_reset();
      #2;
      check_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;

      // Disparity feedback from reset: 1,0,1
      repeat (3) cycle(0, 0, 8'h00, 0, 1);

      // Enable: one OFF cycle, ALIGN_CNT commas, then RUN idle
      cycle(1, 0, 8'h00, 0, 0);
      repeat (ALIGN_CNT + 3) cycle(1, 0, 8'h00, 0, 0);

      // Single data byte
      cycle(1, 1, 8'h4A, 0, 0);
      repeat (2) cycle(1, 0, 8'h4A, 0, 0);

      // Control screening: illegal, legal, two illegal back to back
      cycle(1, 1, 8'h3D, 1, 0);
      cycle(1, 1, 8'hFB, 1, 0);
      cycle(1, 1, 8'h00, 1, 0);
      cycle(1, 1, 8'h1D, 1, 0);
      cycle(1, 0, 8'h00, 0, 0);

      // Continuous stream 00..0F; data advances only on a handshake
      out_q.delete();
      nxt = 8'h00; guard = 0;
      while (nxt != 8'h10 && guard < 60) begin
         rk = m_ready();
         cycle(1, 1, nxt, 0, 0);
         if (rk) nxt++;
         guard++;
      end
      check("stream_done", 8'(guard < 60), 8'd1);
      check("stream_len", 8'(out_q.size()), 8'd16);
      for (int i = 0; i < 16 && i < out_q.size(); i++)
         check("stream_byte", out_q[i], 8'(i));

      // Randomized traffic including occasional enable drops
      for (int i = 0; i < 300; i++) begin
         rk  = ($urandom_range(0, 3) == 0);
         rd8 = (rk && $urandom_range(0, 1) == 1) ? legal_k[$urandom_range(0, 11)] : 8'($urandom);
         cycle($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, rd8, rk,
               $urandom_range(0, 4) == 0);
      end

      // Bring the link to RUN, then drop tx_en with a byte offered
      repeat (ALIGN_CNT + 3) cycle(1, 0, 8'h00, 0, 0);
      if (!m_ready()) cycle(1, 0, 8'h00, 0, 0);
      cycle(0, 1, 8'h55, 0, 0);
      repeat (5) cycle(0, 1, 8'h66, 0, 0);
      repeat (ALIGN_CNT + 3) cycle(1, 1, 8'h77, 0, 0);

      // Asynchronous reset mid-RUN with rd_cur=1
      if (!m_rd) cycle(1, 0, 8'h00, 0, 1);
      cycle(1, 1, 8'h12, 0, 0);
      rst_n = 0;
      model_reset();
      #2;
      check_outputs("async_rst");
      check("async_rst.s_ready", 8'(s_ready), 8'd0);
      @(posedge clk); #1;
      rst_n = 1;
      cycle(1, 0, 8'h00, 0, 0);
      cycle(1, 0, 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit
   initial begin
      #200000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end

endmodule
